// File: rtl/int_ctrl_if.sv
// Bus between int_ctrl and its environment: peripheral lines, memory-mapped
// register port, and the core-side request/acknowledge/RTI handshake.
interface int_ctrl_if #(
  parameter int unsigned NUM_INT = 4
);
  logic [NUM_INT-1:0] irq;
  logic [15:0]        addr;
  logic               we;
  logic               re;
  logic [15:0]        wdata;
  logic [15:0]        rdata;
  logic               int_req;
  logic [15:0]        int_vec;
  logic               int_ack;
  logic               rti;

  modport master (
    output irq, addr, we, re, wdata, int_ack, rti,
    input  rdata, int_req, int_vec
  );

  modport slave (
    input  irq, addr, we, re, wdata, int_ack, rti,
    output rdata, int_req, int_vec
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: NUM_INT-channel edge-latched interrupt controller with fixed priority and
// programmable vector placement. Define NESTED_INT_EN to allow preemption while in service.
module int_ctrl #(
  parameter int unsigned NUM_INT    = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter logic [15:0] VEC_STRIDE = 16'h0010,
  parameter logic [15:0] ADDR_EN    = 16'hC002,
  parameter logic [15:0] ADDR_PEND  = 16'hC003
) (
  input  logic      clk,
  input  logic      rst,
  int_ctrl_if.slave bus
);

  localparam int unsigned IDW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

  typedef logic [IDW-1:0] id_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_INT-1:0] irq_q;
  logic [NUM_INT-1:0] pend_q, pend_d;
  logic [NUM_INT-1:0] en_q, en_d;
  id_t                cur_id_q, cur_id_d;
  logic [15:0]        int_vec_q, int_vec_d;
  logic               int_req_q, int_req_d;

  logic [NUM_INT-1:0] rise_s;
  logic [NUM_INT-1:0] act_s;
  logic [NUM_INT-1:0] clr_s;
  logic               any_s;
  id_t                win_s;
  logic               wr_en_s;
  logic               wr_pend_s;
  logic               ack_s;
  logic [15:0]        rdata_s;
  logic [15:0]        wdata_unused_s;

  function automatic id_t prio_idx(input logic [NUM_INT-1:0] req);
    id_t idx;
    idx = '0;
    for (int i = int'(NUM_INT) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = id_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [15:0] vec_of(input id_t id);
    logic [15:0] off;
    off = VEC_STRIDE * 16'(id);
    return VEC_BASE + off;
  endfunction

  assign rise_s         = bus.irq & ~irq_q;
  assign act_s          = pend_q & en_q;
  assign any_s          = |act_s;
  assign win_s          = prio_idx(act_s);
  assign wr_en_s        = bus.we && (bus.addr == ADDR_EN);
  assign wr_pend_s      = bus.we && (bus.addr == ADDR_PEND);
  assign wdata_unused_s = bus.wdata;

`ifdef NESTED_INT_EN
  localparam int unsigned SPW = $clog2(NUM_INT + 1);

  // Stack entry 0 is the top (most recently accepted, highest-priority level).
  id_t            stk_q [NUM_INT];
  id_t            stk_d [NUM_INT];
  logic [SPW-1:0] sp_q, sp_d;
  logic           push_s;
  logic           pop_s;
`endif

  // Next-state, request latching and handshake decode.
  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    int_vec_d = int_vec_q;
    ack_s     = 1'b0;
`ifdef NESTED_INT_EN
    push_s    = 1'b0;
    pop_s     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d   = ST_REQ;
          cur_id_d  = win_s;
          int_vec_d = vec_of(win_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.int_ack) begin
          state_d = ST_SERVICE;
          ack_s   = 1'b1;
`ifdef NESTED_INT_EN
          push_s  = 1'b1;
`endif
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERVICE: begin
`ifdef NESTED_INT_EN
        if (bus.rti) begin
          pop_s = 1'b1;
          if (sp_q == SPW'(1)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SERVICE;
          end
        end else if (any_s && (win_s < stk_q[0])) begin
          state_d   = ST_REQ;
          cur_id_d  = win_s;
          int_vec_d = vec_of(win_s);
        end else begin
          state_d = ST_SERVICE;
        end
`else
        if (bus.rti) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    int_req_d = (state_d == ST_REQ);
  end

  // Enable and pending update; a fresh edge beats any clear in the same cycle.
  always_comb begin
    if (wr_en_s) begin
      en_d = bus.wdata[NUM_INT-1:0];
    end else begin
      en_d = en_q;
    end
    clr_s = '0;
    if (wr_pend_s) begin
      clr_s = bus.wdata[NUM_INT-1:0];
    end else begin
      clr_s = '0;
    end
    if (ack_s) begin
      clr_s = clr_s | (NUM_INT'(1) << cur_id_q);
    end else begin
      clr_s = clr_s;
    end
    pend_d = (pend_q & ~clr_s) | rise_s;
  end

  // Register read mux.
  always_comb begin
    rdata_s = 16'h0000;
    if (bus.re && (bus.addr == ADDR_EN)) begin
      rdata_s = 16'(en_q);
    end else if (bus.re && (bus.addr == ADDR_PEND)) begin
      rdata_s = 16'(pend_q);
    end else begin
      rdata_s = 16'h0000;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      cur_id_q  <= '0;
      int_vec_q <= 16'h0000;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= bus.irq;
      pend_q    <= pend_d;
      en_q      <= en_d;
      cur_id_q  <= cur_id_d;
      int_vec_q <= int_vec_d;
      int_req_q <= int_req_d;
    end
  end

`ifdef NESTED_INT_EN
  // In-service stack next state: push shifts entries down, pop shifts them up.
  always_comb begin
    stk_d = stk_q;
    if (push_s) begin
      for (int i = int'(NUM_INT) - 1; i > 0; i--) begin
        stk_d[i] = stk_q[i-1];
      end
      stk_d[0] = cur_id_q;
      sp_d     = sp_q + SPW'(1);
    end else if (pop_s) begin
      for (int i = 0; i < int'(NUM_INT) - 1; i++) begin
        stk_d[i] = stk_q[i+1];
      end
      stk_d[NUM_INT-1] = '0;
      sp_d             = sp_q - SPW'(1);
    end else begin
      sp_d = sp_q;
    end
  end

  // In-service stack registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < int'(NUM_INT); i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      stk_q <= stk_d;
    end
  end
`endif

  assign bus.rdata   = rdata_s;
  assign bus.int_req = int_req_q;
  assign bus.int_vec = int_vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl with four channels and default vector map.
module tb_int_ctrl;

  localparam logic [15:0] A_EN   = 16'hC002;
  localparam logic [15:0] A_PEND = 16'hC003;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] rd_v;

  int_ctrl_if #(.NUM_INT(4)) bus ();

  int_ctrl #(
    .NUM_INT   (4),
    .VEC_BASE  (16'h0010),
    .VEC_STRIDE(16'h0010),
    .ADDR_EN   (16'hC002),
    .ADDR_PEND (16'hC003)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
    bus.wdata = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.addr = a;
    bus.re   = 1'b1;
    #1;
    d        = bus.rdata;
    bus.re   = 1'b0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic do_rti();
    bus.rti = 1'b1;
    tick();
    bus.rti = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.irq     = 4'b0000;
    bus.addr    = 16'h0000;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    bus.wdata   = 16'h0000;
    bus.int_ack = 1'b0;
    bus.rti     = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_req", 32'(bus.int_req), 32'h0);
    check_val("rst_vec", 32'(bus.int_vec), 32'h0);
    rd(A_EN, rd_v);
    check_val("rst_en", 32'(rd_v), 32'h0);
    rd(A_PEND, rd_v);
    check_val("rst_pend", 32'(rd_v), 32'h0);

    // Single interrupt on channel 0
    wr(A_EN, 16'h0001);
    bus.irq = 4'b0001;
    tick();
    rd(A_PEND, rd_v);
    check_val("single_pend", 32'(rd_v), 32'h1);
    check_val("single_req_early", 32'(bus.int_req), 32'h0);
    tick();
    check_val("single_req", 32'(bus.int_req), 32'h1);
    check_val("single_vec", 32'(bus.int_vec), 32'h0010);
    ack();
    bus.irq = 4'b0000;
    check_val("single_req_drop", 32'(bus.int_req), 32'h0);
    rd(A_PEND, rd_v);
    check_val("single_pend_clr", 32'(rd_v), 32'h0);
    do_rti();
    tick();
    check_val("single_idle", 32'(bus.int_req), 32'h0);

    // Priority between channels 1 and 3
    wr(A_EN, 16'h000F);
    bus.irq = 4'b1010;
    tick();
    tick();
    check_val("prio_req", 32'(bus.int_req), 32'h1);
    check_val("prio_vec1", 32'(bus.int_vec), 32'h0020);
    rd(A_PEND, rd_v);
    check_val("prio_pend", 32'(rd_v), 32'h000A);
    ack();
    rd(A_PEND, rd_v);
    check_val("prio_pend_after", 32'(rd_v), 32'h0008);
    do_rti();
    check_val("prio_gap", 32'(bus.int_req), 32'h0);
    tick();
    check_val("prio_req2", 32'(bus.int_req), 32'h1);
    check_val("prio_vec3", 32'(bus.int_vec), 32'h0040);
    ack();
    do_rti();
    bus.irq = 4'b0000;
    tick();

    // Masking and write-1-to-clear
    wr(A_EN, 16'h0000);
    bus.irq = 4'b0100;
    tick();
    bus.irq = 4'b0000;
    tick();
    rd(A_PEND, rd_v);
    check_val("mask_pend", 32'(rd_v), 32'h0004);
    check_val("mask_req", 32'(bus.int_req), 32'h0);
    bus.addr = A_PEND;
    #1;
    check_val("noread_rdata", 32'(bus.rdata), 32'h0);
    wr(A_PEND, 16'h0004);
    rd(A_PEND, rd_v);
    check_val("w1c_pend", 32'(rd_v), 32'h0);
    wr(A_EN, 16'h0004);
    rd(A_EN, rd_v);
    check_val("en_read", 32'(rd_v), 32'h0004);
    tick();
    tick();
    check_val("w1c_noreq", 32'(bus.int_req), 32'h0);

    // Set/clear collision on channel 1
    bus.irq = 4'b0010;
    wr(A_PEND, 16'h0002);
    rd(A_PEND, rd_v);
    check_val("collide_pend", 32'(rd_v), 32'h0002);
    bus.irq = 4'b0000;
    wr(A_PEND, 16'h0002);
    rd(A_PEND, rd_v);
    check_val("collide_clr", 32'(rd_v), 32'h0);

    // Higher-priority request while channel 2 is in service
    wr(A_EN, 16'h000F);
    bus.irq = 4'b0100;
    tick();
    tick();
    check_val("nest_req2", 32'(bus.int_req), 32'h1);
    check_val("nest_vec2", 32'(bus.int_vec), 32'h0030);
    ack();
    bus.irq = 4'b0101;
    tick();
    tick();
`ifdef NESTED_INT_EN
    check_val("nest_preempt_req", 32'(bus.int_req), 32'h1);
    check_val("nest_preempt_vec", 32'(bus.int_vec), 32'h0010);
    ack();
    bus.irq = 4'b1101;
    tick();
    do_rti();
    tick();
    check_val("nest_still_service", 32'(bus.int_req), 32'h0);
    do_rti();
    tick();
    check_val("nest_after_pop_req", 32'(bus.int_req), 32'h1);
    check_val("nest_after_pop_vec", 32'(bus.int_vec), 32'h0040);
    ack();
    do_rti();
`else
    check_val("flat_no_preempt", 32'(bus.int_req), 32'h0);
    tick();
    check_val("flat_no_preempt2", 32'(bus.int_req), 32'h0);
    do_rti();
    check_val("flat_rti_gap", 32'(bus.int_req), 32'h0);
    tick();
    check_val("flat_after_rti_req", 32'(bus.int_req), 32'h1);
    check_val("flat_after_rti_vec", 32'(bus.int_vec), 32'h0010);
    ack();
    do_rti();
`endif
    bus.irq = 4'b0000;
    tick();

    // Asynchronous reset while a request is outstanding
    bus.irq = 4'b0010;
    tick();
    tick();
    check_val("rstmid_req_pre", 32'(bus.int_req), 32'h1);
    check_val("rstmid_vec_pre", 32'(bus.int_vec), 32'h0020);
    rst     = 1'b1;
    bus.irq = 4'b0000;
    #1;
    check_val("rstmid_req", 32'(bus.int_req), 32'h0);
    check_val("rstmid_vec", 32'(bus.int_vec), 32'h0);
    rd(A_EN, rd_v);
    check_val("rstmid_en", 32'(rd_v), 32'h0);
    rd(A_PEND, rd_v);
    check_val("rstmid_pend", 32'(rd_v), 32'h0);
    #2 rst = 1'b0;
    tick();
    tick();
    check_val("rstmid_after", 32'(bus.int_req), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised interrupt controller that generalises the fixed four-vector interrupt scheme to NUM_INT channels with programmable vector placement. It latches rising edges on peripheral interrupt lines into a pending register, masks them with a memory-mapped enable register, and arbitrates by fixed priority. It presents one vector at a time to the core with a request/acknowledge handshake and tracks in-service state until the core executes RTI. It sits between the memory-mapped peripherals (SPART, BMP, FFT, switches) and the core's fetch/PC logic.

## Interface
- NUM_INT, 4: number of interrupt channels, 1..16; channel 0 is highest priority.
- VEC_BASE, 16'h0010: vector address of channel 0.
- VEC_STRIDE, 16'h0010: address spacing between consecutive channel vectors.
- ADDR_EN, 16'hC002: memory-mapped address of the enable register.
- ADDR_PEND, 16'hC003: memory-mapped address of the pending register (read; write-1-to-clear).
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- irq  in  NUM_INT  peripheral interrupt lines, level in, rising-edge sensitive, synchronous to clk.
- addr  in  16  data-memory address from core.
- we  in  1  memory write strobe.
- re  in  1  memory read strobe.
- wdata  in  16  write data.
- rdata  out  16  read data; combinational.
- int_req  out  1  interrupt request to core.
- int_vec  out  16  vector of the presented channel; valid while int_req=1.
- int_ack  in  1  core accepts the presented interrupt (one-cycle pulse).
- rti  in  1  core executed RTI (one-cycle pulse).

## Operation
- Edge detect: irq_q <= irq each cycle. pend[i] sets at the posedge where irq[i]=1 and irq_q[i]=0. Pending edges are captured regardless of en.
- Enable: a write (we=1) to ADDR_EN loads en <= wdata[NUM_INT-1:0]. A write to ADDR_PEND clears every pend bit whose wdata bit is 1. If a set and a clear hit the same bit in the same cycle, the set wins.
- Read: when re=1 and addr=ADDR_EN, rdata = en, zero-extended. When re=1 and addr=ADDR_PEND, rdata = pend, zero-extended. Otherwise rdata = 0.
- Arbitration: the winner is the lowest index i with pend[i] & en[i]. Vector = VEC_BASE + i*VEC_STRIDE, computed modulo 2^16.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ when any pend & en bit is set. On that transition, cur_id latches the winner and int_vec is registered.
  - REQ: int_req=1; cur_id and int_vec stay stable until the core acknowledges, even if en or pend change in the meantime.
  - REQ -> SERVICE on int_ack. In the same edge, pend[cur_id] clears, unless a new edge on that channel arrives in that cycle (set wins).
  - SERVICE -> IDLE on rti.
- Ignored inputs: int_ack outside REQ, and rti outside SERVICE.
- Reset values: en=0, pend=0, irq_q=0, state=IDLE, int_req=0, int_vec=0, cur_id=0, rdata=0 (read not asserted). Reset mid-operation aborts any request or service state immediately.

## Timing
- Latency: irq[i] first sampled high at posedge N gives pend[i]=1 after N, state=REQ and int_req=1 after N+1.
- Handshake: int_ack may arrive in any cycle at or after int_req rises. int_req drops the cycle after int_ack is sampled.
- Next request: the earliest new int_req after rti is 1 cycle later (SERVICE -> IDLE -> REQ).
- Register writes take effect at the write edge and affect arbitration in the next IDLE evaluation.

## Configuration
- NESTED_INT_EN defined:
  - In SERVICE, a pending enabled channel with index strictly lower than the current top-of-stack raises a new REQ.
  - On that int_ack its id is pushed onto an in-service stack of depth NUM_INT.
  - rti pops the stack. Return to IDLE occurs only when the stack is empty.
  - Lower- or equal-priority channels wait until they outrank the top of stack, or until the stack empties.
- NESTED_INT_EN undefined: single in-service level. No preemption in SERVICE; all requests wait for rti.

## Test plan
- Single interrupt: en=4'b0001; raise irq[0] -> int_req=1 two cycles later with int_vec=16'h0010. int_ack -> pend=0. rti -> IDLE.
- Priority: en=4'hF; irq[3] and irq[1] rise together -> vector 16'h0020 first. After ack+rti -> vector 16'h0040.
- Masking and write-1-to-clear: en=0; pulse irq[2] -> read ADDR_PEND=16'h0004, int_req stays 0. Write 16'h0004 to ADDR_PEND -> read 0. Set en=4'h4 -> no request.
- Set/clear collision: irq[1] edge in the same cycle as a write-1-to-clear of bit 1 -> pend[1]=1 afterwards.
- Nesting: channel 2 in service, irq[0] rises. With NESTED_INT_EN: int_req with 16'h0010; two rti pulses needed to reach IDLE. Without the macro: no request until rti.
- Reset mid-REQ: assert rst while int_req=1 -> int_req=0, int_vec=0, en=0, pend=0 asynchronously.
